// File: rtl/pcam_writer.sv
// Collects BIST fault addresses into a small CAM-like repair table with per-entry
// saturating hit counters. The table freezes for the redundancy-analysis reader once test_done arrives.
module pcam_writer #(
  parameter int PCAM   = 8,
  parameter int ADDR_W = 10,
  parameter int HIT_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       fault_valid,
  input  logic [ADDR_W-1:0]          fault_addr,
  output logic                       fault_ready,
  input  logic                       test_done,
  output logic [PCAM*ADDR_W-1:0]     pcam_addr,
  output logic [PCAM-1:0]            pcam_vld,
  output logic [PCAM*HIT_W-1:0]      pcam_hit,
  output logic [$clog2(PCAM+1)-1:0]  pcam_cnt,
  output logic                       overflow,
  output logic                       table_rdy,
  output logic [1:0]                 dbg_state
);

  localparam int CNT_W = $clog2(PCAM+1);
  localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, FROZEN = 2'd2} state_t;

  // Handshake: a fault transfers on a rising edge where fault_valid && fault_ready;
  // fault_ready is a register, so it never depends combinationally on fault_valid.
  state_t              state, state_nxt;
  logic                ready_q;
  logic                done_pend;
  logic [ADDR_W-1:0]   lat_addr;
  logic [ADDR_W-1:0]   addr_q [PCAM];
  logic [HIT_W-1:0]    hit_q  [PCAM];
  logic [PCAM-1:0]     vld_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q;
  logic [PCAM-1:0]     match;
  logic                any_hit;
  logic                accept;

  assign accept = (state == IDLE) && fault_valid && ready_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      done_pend <= 1'b0;
      lat_addr  <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == IDLE);
      if (clear || state == CHECK)
        done_pend <= 1'b0;
      else if (accept && test_done)
        done_pend <= 1'b1;
      if (accept)
        lat_addr <= fault_addr;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept)         state_nxt = CHECK;
        else if (test_done) state_nxt = FROZEN;
      end
      CHECK:   state_nxt = (done_pend || test_done) ? FROZEN : IDLE;
      FROZEN:  state_nxt = FROZEN;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Outputs decoded from state
  always_comb begin
    fault_ready = ready_q;
    table_rdy   = (state == FROZEN);
    dbg_state   = state;
  end

  // Entries are unique by construction, so an OR of independent matches needs no priority.
  always_comb begin
    for (int i = 0; i < PCAM; i++)
      match[i] = vld_q[i] && (addr_q[i] == lat_addr);
    any_hit = |match;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PCAM; i++) begin
        addr_q[i] <= '0;
        hit_q[i]  <= '0;
      end
      vld_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < PCAM; i++) begin
        addr_q[i] <= '0;
        hit_q[i]  <= '0;
      end
      vld_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (state == CHECK) begin
      if (any_hit) begin
        for (int i = 0; i < PCAM; i++)
          if (match[i] && hit_q[i] != HIT_MAX)
            hit_q[i] <= hit_q[i] + 1'b1;
      end else if (cnt_q < CNT_W'(PCAM)) begin
        for (int i = 0; i < PCAM; i++)
          if (cnt_q == CNT_W'(i)) begin
            addr_q[i] <= lat_addr;
            hit_q[i]  <= HIT_W'(1);
            vld_q[i]  <= 1'b1;
          end
        cnt_q <= cnt_q + 1'b1;
      end else begin
        ovf_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < PCAM; g++) begin : g_flat
    assign pcam_addr[g*ADDR_W +: ADDR_W] = addr_q[g];
    assign pcam_hit[g*HIT_W +: HIT_W]    = hit_q[g];
  end

  assign pcam_vld = vld_q;
  assign pcam_cnt = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pcam_writer.sv
// Directed bench for pcam_writer: fills, saturation, overflow, back-to-back
// handshakes, freeze, clear and asynchronous reset, all with hand-computed expectations.
module tb_pcam_writer;

  localparam int PCAM = 8, ADDR_W = 10, HIT_W = 3;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b1;
  logic                       clear = 1'b0;
  logic                       fault_valid = 1'b0;
  logic [ADDR_W-1:0]          fault_addr = '0;
  logic                       fault_ready;
  logic                       test_done = 1'b0;
  logic [PCAM*ADDR_W-1:0]     pcam_addr;
  logic [PCAM-1:0]            pcam_vld;
  logic [PCAM*HIT_W-1:0]      pcam_hit;
  logic [$clog2(PCAM+1)-1:0]  pcam_cnt;
  logic                       overflow;
  logic                       table_rdy;
  logic [1:0]                 dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  pcam_writer #(.PCAM(PCAM), .ADDR_W(ADDR_W), .HIT_W(HIT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_ready(fault_ready),
    .test_done(test_done), .pcam_addr(pcam_addr), .pcam_vld(pcam_vld),
    .pcam_hit(pcam_hit), .pcam_cnt(pcam_cnt), .overflow(overflow),
    .table_rdy(table_rdy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] entry(input int i);
    return pcam_addr[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [HIT_W-1:0] hit(input int i);
    return pcam_hit[i*HIT_W +: HIT_W];
  endfunction

  // Drivers: all inputs change on the falling edge, outputs are sampled there too.
  task automatic send_fault(input logic [ADDR_W-1:0] a);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fault_ready) begin
        fault_valid = 1'b1;
        fault_addr  = a;
        @(negedge clk);
        fault_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_vld"}, pcam_vld, 0);
    check({tag, "_cnt"}, pcam_cnt, 0);
    check({tag, "_addr"}, pcam_addr, 0);
    check({tag, "_hit"}, pcam_hit, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    // Reset state while rst_n is held low
    #2 rst_n = 1'b0;
    #1;
    check_empty("rst");
    check("rst_ready", fault_ready, 0);
    check("rst_tbl_rdy", table_rdy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_rel_ready0", fault_ready, 0);
    @(negedge clk);
    check("rst_rel_ready1", fault_ready, 1);

    // Three distinct faults fill entries 0..2
    send_fault(10'h012);
    send_fault(10'h034);
    send_fault(10'h056);
    @(negedge clk);
    check("fill_e0", entry(0), 10'h012);
    check("fill_e1", entry(1), 10'h034);
    check("fill_e2", entry(2), 10'h056);
    check("fill_vld", pcam_vld, 8'h07);
    check("fill_cnt", pcam_cnt, 3);
    for (int i = 0; i < 3; i++) check("fill_hit", hit(i), 1);

    // Same fault nine times saturates at 7
    do_clear();
    check_empty("clr1");
    for (int k = 0; k < 9; k++) send_fault(10'h012);
    @(negedge clk);
    check("sat_cnt", pcam_cnt, 1);
    check("sat_vld", pcam_vld, 8'h01);
    check("sat_hit0", hit(0), 7);
    check("sat_ovf", overflow, 0);

    // Nine distinct faults overflow the table
    do_clear();
    for (int k = 1; k <= 9; k++) send_fault(ADDR_W'(k));
    @(negedge clk);
    check("ovf_vld", pcam_vld, 8'hFF);
    check("ovf_cnt", pcam_cnt, 8);
    check("ovf_e7", entry(7), 10'h008);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < PCAM; i++) check("ovf_entry", entry(i), ADDR_W'(i + 1));
    send_fault(10'h001);
    @(negedge clk);
    check("ovf_sticky", overflow, 1);
    check("ovf_hit_after", hit(0), 2);

    // fault_valid held high: ready alternates, one accept per two cycles
    do_clear();
    check("clr_ovf", overflow, 0);
    for (int k = 0; k < 8; k++) begin
      fault_valid = 1'b1;
      fault_addr  = ADDR_W'(10'h100 + k);
      check("b2b_ready", fault_ready, (k % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end
    fault_valid = 1'b0;
    check("b2b_cnt", pcam_cnt, 4);
    check("b2b_e1", entry(1), 10'h102);
    check("b2b_e3", entry(3), 10'h106);

    // test_done during CHECK: fault completes, then frozen
    do_clear();
    @(negedge clk);
    fault_valid = 1'b1;
    fault_addr  = 10'h0AA;
    @(negedge clk);
    fault_valid = 1'b0;
    test_done   = 1'b1;
    check("frz_in_check", dbg_state, 1);
    @(negedge clk);
    test_done = 1'b0;
    check("frz_e0", entry(0), 10'h0AA);
    check("frz_tbl_rdy", table_rdy, 1);
    check("frz_ready", fault_ready, 0);
    fault_valid = 1'b1;
    fault_addr  = 10'h0BB;
    repeat (3) @(negedge clk);
    fault_valid = 1'b0;
    check("frz_cnt_held", pcam_cnt, 1);
    check("frz_vld_held", pcam_vld, 8'h01);
    do_clear();
    check_empty("frz_clr");
    check("frz_clr_tbl", table_rdy, 0);
    check("frz_clr_ready", fault_ready, 1);

    // test_done together with a handshake: fault checked, then frozen
    @(negedge clk);
    fault_valid = 1'b1;
    fault_addr  = 10'h0CC;
    test_done   = 1'b1;
    @(negedge clk);
    fault_valid = 1'b0;
    test_done   = 1'b0;
    @(negedge clk);
    check("done_hs_e0", entry(0), 10'h0CC);
    check("done_hs_cnt", pcam_cnt, 1);
    check("done_hs_tbl", table_rdy, 1);
    do_clear();

    // Asynchronous reset mid-CHECK after four entries
    for (int k = 0; k < 4; k++) send_fault(ADDR_W'(10'h200 + k));
    @(negedge clk);
    check("arst_pre_cnt", pcam_cnt, 4);
    fault_valid = 1'b1;
    fault_addr  = 10'h2FF;
    @(negedge clk);
    fault_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_empty("arst");
    check("arst_ready", fault_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("arst_rel_ready0", fault_ready, 0);
    @(negedge clk);
    check("arst_rel_ready1", fault_ready, 1);
    @(negedge clk);
    check("arst_dropped_cnt", pcam_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 64'd0, 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcam_writer.md
PCAM_WRITER -- requirements
Module: pcam_writer

Interface
REQ-001 SHALL have parameter PCAM, default 8, meaning number of PCAM entries.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning fault address width.
REQ-003 SHALL have parameter HIT_W, default 3, meaning per-entry saturating hit counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush of all entries and flags.
REQ-007 SHALL have port fault_valid, input, 1 bit: BIST fault address offered.
REQ-008 SHALL have port fault_addr, input, ADDR_W bits: faulty address.
REQ-009 SHALL have port fault_ready, output, 1 bit: writer can accept a fault.
REQ-010 SHALL have port test_done, input, 1 bit: BIST finished; freeze table.
REQ-011 SHALL have port pcam_addr, output, PCAM*ADDR_W bits: entry i in bits [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port pcam_vld, output, PCAM bits: bit i set when entry i holds an address.
REQ-013 SHALL have port pcam_hit, output, PCAM*HIT_W bits: occurrence count of entry i, same slicing.
REQ-014 SHALL have port pcam_cnt, output, $clog2(PCAM+1) bits: number of valid entries.
REQ-015 SHALL have port overflow, output, 1 bit: sticky, new unique fault arrived with table full.
REQ-016 SHALL have port table_rdy, output, 1 bit: table frozen and stable for the redundancy-analysis reader.

Function
REQ-017 SHALL implement FSM states IDLE, CHECK, FROZEN.
REQ-018 IDLE: fault_ready=1; handshake fault_valid&fault_ready latches fault_addr into an internal register and moves to CHECK.
REQ-019 CHECK: fault_ready=0; latched address compared against all valid entries in one cycle; returns to IDLE next edge; throughput one fault per 2 cycles.
REQ-020 Hit (match on a valid entry): that entry's hit counter increments, saturating at 2^HIT_W-1; no new entry; pcam_cnt unchanged.
REQ-021 Miss, pcam_cnt<PCAM: write address to entry index pcam_cnt, set its vld bit, hit counter=1, pcam_cnt+1; entries fill in order 0,1,2...
REQ-022 Miss, pcam_cnt==PCAM: table unchanged, overflow set and held until clear or reset.
REQ-023 More than one matching entry is impossible by construction; compare logic SHALL not depend on priority.
REQ-024 test_done in IDLE moves to FROZEN next edge; in CHECK, current fault completes, then FROZEN instead of IDLE.
REQ-025 test_done and a fault handshake in the same IDLE cycle: the fault is accepted and checked, then FROZEN.
REQ-026 FROZEN: fault_ready=0, table_rdy=1, all table outputs held; leaves only via clear or reset.
REQ-027 clear has priority over all other inputs in any state: next edge all vld=0, hit=0, addr=0, pcam_cnt=0, overflow=0, state IDLE; an in-flight CHECK is discarded.
REQ-028 All outputs SHALL be registered or decoded from state only; no combinational path from fault_valid to fault_ready.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, pcam_addr=0, pcam_vld=0, pcam_hit=0, pcam_cnt=0, overflow=0, table_rdy=0, fault_ready=0 while asserted.
REQ-030 fault_ready SHALL rise on the first clock edge after rst_n deasserts; reset mid-CHECK drops the pending fault.

Verification
REQ-031 Faults 0x012, 0x034, 0x056 one per handshake -> entries 0..2 = 0x012,0x034,0x056, pcam_vld=8'h07, pcam_cnt=3, hits=1.
REQ-032 Fault 0x012 sent 9 times -> one entry, pcam_cnt=1, hit[0]=7 (saturated), overflow=0.
REQ-033 9 distinct faults 0x001..0x009 -> pcam_vld=8'hFF, pcam_cnt=8, entry 7=0x008, overflow=1, 0x009 absent.
REQ-034 fault_valid held high continuously -> fault_ready toggles 1,0,1,0; exactly one accept per 2 cycles.
REQ-035 test_done during CHECK of 0x0AA -> 0x0AA stored, then table_rdy=1, fault_ready=0, further faults ignored; clear -> all zero, IDLE.
REQ-036 rst_n pulsed low mid-CHECK after 4 entries -> outputs zero asynchronously, fault_ready=1 one edge after release.
